seq_mult_unit: RTL and testbench
================================

Name: seq_mult_unit

Overview:
Multi-cycle radix-2 shift-add multiplier that responds to the data path's start_mult/mult_sign request. It sits beside the execute-stage ALU. It latches the two 32-bit operands when start_mult is sampled, iterates for 32 cycles, then returns a 64-bit product as hi/lo with a one-cycle done pulse. busy is used by hazard logic to stall mfhi/mflo and new mult instructions.

Parameters:
WIDTH, 32, operand width; product width is 2*WIDTH.
CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start_mult  input  1  request; sampled only while idle.
mult_sign  input  1  1 = signed (mult), 0 = unsigned (multu); latched with start_mult.
srca  input  WIDTH  multiplicand from the execute stage.
srcb  input  WIDTH  multiplier from the execute stage.
busy  output  1  high while in RUN or FIX.
done  output  1  one-cycle completion pulse.
prod_hi  output  WIDTH  upper half of the last completed product.
prod_lo  output  WIDTH  lower half of the last completed product.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; busy = 0; done = 0; prod_hi = 0; prod_lo = 0; counter = 0.
  - Reset overrides every other input.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE:
  - On start_mult = 1 at edge E0, latch the operands:
    - signed: latch |srca| and |srcb|, and neg = srca[31] ^ srcb[31].
    - unsigned: latch the raw operands, and neg = 0.
  - Clear the accumulator and counter, then go to RUN.
  - |0x80000000| is the unsigned value 0x80000000; no overflow handling is needed.
- RUN:
  - Each edge E1..E32 performs one iteration: if multiplier bit 0 = 1, add the multiplicand into the upper accumulator half with carry out.
  - Then shift {carry, acc} right by 1 and increment the counter.
  - At E32 (counter = 31) go to FIX.
- FIX:
  - At E33, write {prod_hi, prod_lo} = neg ? two's complement of acc : acc.
  - Set done = 1 and go to IDLE.
- done:
  - High for exactly one cycle, following E33.
  - Latency from sampling start_mult to visible done/result is 33 clocks.
- prod_hi/prod_lo hold their value until the next FIX; they never change during RUN.
- srca, srcb and mult_sign are ignored after E0; changes during busy have no effect.
- start_mult while busy is ignored, not queued.
- Back-to-back operation: start_mult in the cycle where done = 1 (state is already IDLE) is accepted. The new result overwrites hi/lo 33 cycles later.
- done and start_mult acceptance never occur on the same edge, because start is only sampled in IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'b00, RUN = 2'b01, FIX = 2'b10.
  - MULT_WIDTH = 32 and MULT_LATENCY = 33, used by the hazard unit and the bench.
- Single module; no sub-module is warranted. Absolute value and negation are inline expressions.

Test Plan:
- Unsigned 7 x 6 → done after 33 clocks; prod_hi = 0x00000000, prod_lo = 0x0000002A; busy high for exactly 33 cycles.
- Signed -3 (0xFFFFFFFD) x 5 → prod_hi = 0xFFFFFFFF, prod_lo = 0xFFFFFFF1.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF → prod_hi = 0xFFFFFFFE, prod_lo = 0x00000001.
- Signed 0x80000000 x 0x80000000 → prod_hi = 0x40000000, prod_lo = 0x00000000.
- Busy handling:
  - Start 2 x 3, then pulse start_mult with 9 x 9 at cycle 10 and change srca at cycle 5.
  - Required: the second start is ignored and a single done pulse occurs.
  - Result is 6; a back-to-back start in the done cycle with 4 x 4 gives 16 after 33 more clocks.
- Reset mid-operation:
  - After a completed 7 x 6 result, start 5 x 5, then assert reset at cycle 12.
  - Required: busy = 0, done = 0, hi/lo = 0 on the next cycle, and no done pulse appears afterwards.

Source files
------------

// File: rtl/seq_mult_unit_pkg.sv
// Shared constants for the sequential multiplier: state encoding, operand
// width and result latency as seen by the hazard unit.
package seq_mult_unit_pkg;

    localparam int MULT_WIDTH   = 32;
    localparam int MULT_LATENCY = 33;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mult_state_e;

endpackage

// File: rtl/seq_mult_unit_if.sv
// Request/result bundle between the execute stage (master) and the multiplier (slave).
interface seq_mult_unit_if;
    import seq_mult_unit_pkg::*;

    logic                  start_mult;
    logic                  mult_sign;
    logic [MULT_WIDTH-1:0] srca;
    logic [MULT_WIDTH-1:0] srcb;
    logic                  busy;
    logic                  done;
    logic [MULT_WIDTH-1:0] prod_hi;
    logic [MULT_WIDTH-1:0] prod_lo;

    modport master (
        output start_mult, mult_sign, srca, srcb,
        input  busy, done, prod_hi, prod_lo
    );

    modport slave (
        input  start_mult, mult_sign, srca, srcb,
        output busy, done, prod_hi, prod_lo
    );

endinterface

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-add multiplier: sign-magnitude operands, WIDTH iterations,
// then a single fix-up cycle that applies the sign and publishes hi/lo.
module seq_mult_unit
    import seq_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    seq_mult_unit_if.slave bus
);

    if (CNT_W != $clog2(WIDTH)) begin : g_bad_cnt_w
        $error("CNT_W must equal clog2(WIDTH)");
    end

    mult_state_e            r_state;
    mult_state_e            w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_mcand;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_neg;
    logic                   r_done;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_upper;
    logic [2*WIDTH-1:0]     w_acc_shift;
    logic [2*WIDTH-1:0]     w_prod;

    assign w_abs_a = (bus.mult_sign && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    assign w_abs_b = (bus.mult_sign && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

    // Low half of the accumulator starts as the multiplier and is shifted out
    // one bit per iteration while the product fills in from the top.
    assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_upper     = r_acc[0] ? w_sum : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_acc_shift = {w_upper, r_acc[WIDTH-1:1]};
    assign w_prod      = r_neg ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_mult) w_next = RUN;
            RUN:     if (r_cnt == CNT_W'(WIDTH - 1)) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_mult) begin
                        r_mcand <= w_abs_a;
                        r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                        r_neg   <= bus.mult_sign & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_shift;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    {r_hi, r_lo} <= w_prod;
                    r_done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.prod_hi = r_hi;
    assign bus.prod_lo = r_lo;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit: directed corners, random operands
// against a 64-bit arithmetic model, busy/back-to-back and mid-op reset.
module tb_seq_mult_unit;
    import seq_mult_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seq_mult_unit_if bus ();

    seq_mult_unit #(.WIDTH(MULT_WIDTH), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] last_prod = '0;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Entered and left at a negedge; returns on the negedge where done is seen.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input bit disturb);
        int done_k = 0;
        int busy_n;
        bit held = 1'b1;
        bus.start_mult = 1'b1;
        bus.srca       = a;
        bus.srcb       = b;
        bus.mult_sign  = sgn;
        @(posedge clk); @(negedge clk);
        bus.start_mult = 1'b0;
        busy_n = int'(bus.busy);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) begin
                done_k = k;
                break;
            end
            busy_n += int'(bus.busy);
            if ({bus.prod_hi, bus.prod_lo} !== last_prod) held = 1'b0;
            if (disturb && k == 5) begin
                bus.srca      = ~a;
                bus.mult_sign = ~sgn;
            end
            if (disturb && k == 10) begin
                bus.start_mult = 1'b1;
                bus.srca       = 32'd9;
                bus.srcb       = 32'd9;
            end
            if (disturb && k == 11) bus.start_mult = 1'b0;
        end
        n_cmp++;
        if (done_k !== MULT_LATENCY) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, done_k, MULT_LATENCY);
        end
        n_cmp++;
        if ({bus.prod_hi, bus.prod_lo} !== exp) begin
            n_bad++;
            $display("FAIL %s product: got %h want %h", nm, {bus.prod_hi, bus.prod_lo}, exp);
        end
        n_cmp++;
        if (busy_n !== MULT_LATENCY || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy: high %0d cycles (want %0d), at done %b want 0",
                     nm, busy_n, MULT_LATENCY, bus.busy);
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++;
            $display("FAIL %s hold: product changed while busy, want %h held", nm, last_prod);
        end
        last_prod = exp;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start_mult = 1'b1;
        bus.mult_sign  = 1'b0;
        bus.srca       = 32'd3;
        bus.srcb       = 32'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset ctl: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_cmp++;
        if ({bus.prod_hi, bus.prod_lo} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset prod: got %h want 0", {bus.prod_hi, bus.prod_lo});
        end
        bus.start_mult = 1'b0;
        reset = 1'b0;
        last_prod = '0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("u7x6",    32'd7,        32'd6,        1'b0, 64'h00000000_0000002A, 1'b0);
        run_op("s-3x5",   32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
        run_op("umax2",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1'b0);
        run_op("smin2",   32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 1'b0);
        run_op("s-1x-1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 1'b0);
        run_op("sminx1",  32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF_80000000, 1'b0);
        run_op("u0xmax",  32'd0,        32'hFFFFFFFF, 1'b0, 64'd0,                 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 5 == 0) a[31] = 1'b1;
            if (i % 7 == 0) b = 32'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d", i), a, b, s, ref_mul(a, b, s), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        bit quiet = 1'b1;
        run_op("busy2x3", 32'd2, 32'd3, 1'b0, 64'd6, 1'b1);
        run_op("b2b4x4",  32'd4, 32'd4, 1'b0, 64'd16, 1'b0);
        bus.srca = 32'd9;
        bus.srcb = 32'd9;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.prod_hi, bus.prod_lo} !== 64'd16)
                quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b tail: extra activity (done=%b busy=%b prod=%h) want idle with 16",
                     bus.done, bus.busy, {bus.prod_hi, bus.prod_lo});
        end
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        run_op("pre7x6", 32'd7, 32'd6, 1'b0, 64'd42, 1'b0);
        bus.start_mult = 1'b1;
        bus.srca       = 32'd5;
        bus.srcb       = 32'd5;
        bus.mult_sign  = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.start_mult = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst ctl: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_cmp++;
        if ({bus.prod_hi, bus.prod_lo} !== 64'd0) begin
            n_bad++;
            $display("FAIL midrst prod: got %h want 0", {bus.prod_hi, bus.prod_lo});
        end
        reset = 1'b0;
        last_prod = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst tail: done/busy seen after abort, want none");
        end
    endtask

    initial begin
        bus.start_mult = 1'b0;
        bus.mult_sign  = 1'b0;
        bus.srca       = '0;
        bus.srcb       = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
